// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone timer.
// Register offsets, CTRL/STATUS bit positions, FSM encoding and the LIMIT reset value.
package wb_timer_pkg;

  // Word offsets (wb_adr_i[3:2])
  localparam logic [1:0] ADR_CTRL   = 2'd0;
  localparam logic [1:0] ADR_LIMIT  = 2'd1;
  localparam logic [1:0] ADR_PRESC  = 2'd2;
  localparam logic [1:0] ADR_STATUS = 2'd3;

  // CTRL bits
  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_CLR     = 2;

  // STATUS bits
  localparam int STAT_EXP = 0;
  localparam int STAT_RUN = 1;
  localparam int STAT_IE  = 2;

  localparam int LIMIT_RST = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tmr_state_t;

  // Replace only the byte lanes flagged in sel.
  function automatic logic [31:0] sel_merge(input logic [31:0] old,
                                            input logic [31:0] wdat,
                                            input logic [3:0]  sel);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[i*8 +: 8] = wdat[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_core.sv
// Timer core: prescaler, counter and IDLE/RUN/DONE state machine.
// expire is the combinational wrap event; tick is its registered one-cycle pulse.
module timer_core
  import wb_timer_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               oneshot,
  input  logic               clr,
  input  logic [CNT_W-1:0]   limit,
  input  logic [PRESC_W-1:0] presc,
  output logic               running,
  output logic [CNT_W-1:0]   cnt,
  output logic               expire,
  output logic               tick
);

  tmr_state_t         state;
  logic [PRESC_W-1:0] psc;
  logic               adv;
  logic               at_end;

  // Prescaler match uses >= so a PRESC lowered below the running prescaler still advances.
  assign adv     = (psc >= presc);
  // Wrap when advancing from LIMIT-1, or when LIMIT was lowered below the count.
  assign at_end  = (({1'b0, cnt} + 1'b1) >= {1'b0, limit});
  assign expire  = (state == ST_RUN) && en && !clr && adv && at_end;
  assign running = (state == ST_RUN);

  // State, prescaler, counter and tick register; CLR overrides any advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      psc   <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= expire;
      if (clr) begin
        psc <= '0;
        cnt <= '0;
      end
      case (state)
        ST_IDLE: begin
          if (en && (limit != '0)) state <= ST_RUN;
        end
        ST_RUN: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (!clr) begin
            if (adv) begin
              psc <= '0;
              if (at_end) begin
                cnt <= '0;
                if (oneshot) state <= ST_DONE;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              psc <= psc + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!en || clr) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wb_timer_ctrl.sv
// Wishbone-controlled timer: register decode, bus handshake and status.
// Optional macro WB_TIMER_IRQ_EN adds the irq output and the IE bit.
module wb_timer_ctrl
  import wb_timer_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        tick,
  output logic [3:0]  display_time_digit
`ifdef WB_TIMER_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic               en_r;
  logic               oneshot_r;
  logic [CNT_W-1:0]   limit_r;
  logic [PRESC_W-1:0] presc_r;
  logic               exp_r;
  logic               ie_r;
  logic               running;
  logic               expire;
  logic [CNT_W-1:0]   cnt;
  logic               acc;
  logic               wr;
  logic [1:0]         adr;
  logic               clr;
  logic               w1c;
  logic [31:0]        rdata;
  logic               unused_adr;

  assign adr        = wb_adr_i[3:2];
  assign unused_adr = ^{wb_adr_i[31:4], wb_adr_i[1:0]};
  // A new access is one not already being acknowledged.
  assign acc = wb_cyc_i && wb_stb_i && !wb_ack_o;
  assign wr  = acc && wb_we_i;
  assign clr = wr && (adr == ADR_CTRL) && wb_sel_i[0] && wb_dat_i[CTRL_CLR];
  assign w1c = wr && (adr == ADR_STATUS) && wb_sel_i[0] && wb_dat_i[STAT_EXP];

  assign display_time_digit = cnt[3:0];

  timer_core #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .en      (en_r),
    .oneshot (oneshot_r),
    .clr     (clr),
    .limit   (limit_r),
    .presc   (presc_r),
    .running (running),
    .cnt     (cnt),
    .expire  (expire),
    .tick    (tick)
  );

  // Read mux; unused bits are zero.
  always_comb begin
    rdata = '0;
    case (adr)
      ADR_CTRL:   rdata = {30'b0, oneshot_r, en_r};
      ADR_LIMIT:  rdata = 32'(limit_r);
      ADR_PRESC:  rdata = 32'(presc_r);
      ADR_STATUS: rdata = {29'b0, ie_r, running, exp_r};
      default:    rdata = '0;
    endcase
  end

  // One registered ack per access, read data captured alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= acc;
      if (acc) wb_dat_o <= rdata;
    end
  end

  // Register writes; a hardware expiry beats a simultaneous EXP clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_r      <= 1'b0;
      oneshot_r <= 1'b0;
      limit_r   <= CNT_W'(LIMIT_RST);
      presc_r   <= '0;
      exp_r     <= 1'b0;
    end else begin
      if (expire)   exp_r <= 1'b1;
      else if (w1c) exp_r <= 1'b0;
      if (wr) begin
        case (adr)
          ADR_CTRL: begin
            if (wb_sel_i[0]) begin
              en_r      <= wb_dat_i[CTRL_EN];
              oneshot_r <= wb_dat_i[CTRL_ONESHOT];
            end
          end
          ADR_LIMIT: limit_r <= CNT_W'(sel_merge(32'(limit_r), wb_dat_i, wb_sel_i));
          ADR_PRESC: presc_r <= PRESC_W'(sel_merge(32'(presc_r), wb_dat_i, wb_sel_i));
          default: ;
        endcase
      end
    end
  end

`ifdef WB_TIMER_IRQ_EN
  // Interrupt enable bit and registered interrupt output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_r <= 1'b0;
      irq  <= 1'b0;
    end else begin
      if (wr && (adr == ADR_STATUS) && wb_sel_i[0]) ie_r <= wb_dat_i[STAT_IE];
      irq <= exp_r && ie_r;
    end
  end
`else
  assign ie_r = 1'b0;
`endif

endmodule

// File: doc/wb_timer_ctrl.md
WB_TIMER_CTRL -- requirements
Module: wb_timer_ctrl

Interface
REQ-001 SHALL provide parameter CNT_W, default 16, counter/limit width (4..32).
REQ-002 SHALL provide parameter PRESC_W, default 8, prescaler register width (1..16).
REQ-003 SHALL have one clock and an asynchronous, active-high reset, using these ports:
  - clk  in  1  system clock, all state on rising edge.
  - rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL expose the Wishbone slave ports:
  - wb_adr_i  in  32  byte address; bits [3:2] decoded.
  - wb_dat_i  in  32  write data.
  - wb_sel_i  in  4  byte lanes; writes apply only to selected lanes.
  - wb_cyc_i, wb_stb_i, wb_we_i  in  1  classic-cycle controls.
  - wb_dat_o  out  32  read data.
  - wb_ack_o  out  1  transfer acknowledge.
REQ-005 SHALL expose the timer outputs:
  - tick  out  1  one-cycle pulse on counter wrap/expiry.
  - display_time_digit  out  4  count[3:0].
  - irq  out  1  interrupt, present only with the configuration macro.

Function
REQ-006 SHALL decode the register map:
  - 0x0 CTRL RW: [0] EN, [1] ONESHOT, [2] CLR (write-1 self-clearing, reads 0).
  - 0x4 LIMIT RW [CNT_W-1:0].
  - 0x8 PRESC RW [PRESC_W-1:0].
  - 0xC STATUS: [0] EXP (sticky, write-1-to-clear), [1] RUNNING (RO), [2] IE (RW).
  - Unused bits read 0.
REQ-007 SHALL assert wb_ack_o for exactly one cycle, registered, in the cycle after wb_cyc_i&wb_stb_i are first seen high; no ack while ack is already high (one ack per access).
REQ-008 SHALL commit writes and return read data (registered wb_dat_o) in the same cycle ack is asserted.
REQ-009 SHALL implement the FSM IDLE -> RUN -> DONE:
  - IDLE -> RUN when EN=1 and LIMIT!=0.
  - RUN -> IDLE when EN is cleared.
  - RUN -> DONE on expiry when ONESHOT=1.
  - DONE -> IDLE when EN is cleared or CLR is written.
REQ-010 SHALL, in RUN, increment the prescaler every cycle; when prescaler==PRESC it resets to 0 and the counter advances by one.
REQ-011 SHALL, when the counter advances from LIMIT-1, reset the counter to 0, pulse tick for one cycle, and set EXP; with ONESHOT=1 the FSM enters DONE and the counter holds 0.
REQ-012 SHALL make a CLR write reset the prescaler and counter to 0 without changing EN or EXP; if CLR coincides with expiry, CLR wins (no tick, EXP not set).
REQ-013 SHALL, if LIMIT is written below the current count, wrap at the next advance: counter to 0, tick, and EXP set.
REQ-014 SHALL give a hardware EXP set priority over a simultaneous W1C clear (EXP stays 1).
REQ-015 SHALL, in IDLE/DONE, hold the counter and prescaler; RUNNING=1 only in RUN.
REQ-016 SHALL, with LIMIT=0 and EN=1, stay in IDLE with no tick.

Reset
REQ-017 SHALL set on rst:
  - CTRL=0, LIMIT=10, PRESC=0, STATUS=0, counter=0, prescaler=0, FSM=IDLE.
  - Outputs wb_ack_o=0, wb_dat_o=0, tick=0, irq=0, display_time_digit=0.
REQ-018 SHALL, on rst mid-bus-cycle, drop ack immediately; a pending access is lost and the master re-issues it.

Configuration
REQ-019 SHALL, with WB_TIMER_IRQ_EN defined, drive irq = EXP & IE, registered.
REQ-020 SHALL, without WB_TIMER_IRQ_EN, omit the irq port; the IE bit reads 0 and ignores writes.

Structure
REQ-021 SHALL place register offsets, CTRL/STATUS bit indices, FSM state encoding and the LIMIT reset value in the shared package wb_timer_pkg.
REQ-022 SHALL split out one sub-module, timer_core (prescaler, counter and FSM); the top holds the Wishbone decode and registers.

Verification
REQ-023 Bench SHALL cover:
  - Reset: read 0x0/0x4/0x8/0xC -> 0x0/0xA/0x0/0x0; ack exactly one cycle per access.
  - LIMIT=3, PRESC=0, EN=1 -> tick every 3 cycles; digit sequence 0,1,2,0; EXP=1.
  - PRESC=1, LIMIT=2, ONESHOT=1, EN=1 -> a single tick 4 cycles after entering RUN; state DONE; RUNNING=0.
  - CLR written in the expiry cycle -> no tick, count=0, EXP unchanged; W1C of EXP together with a hardware set -> EXP=1.
  - With WB_TIMER_IRQ_EN: IE=1 and expiry -> irq=1 the next cycle; write 1 to STATUS[0] -> irq=0.
  - Assert rst during RUN at count=5 with ack pending -> all outputs 0 asynchronously; count=0 after release.
